// File: rtl/gray_code_counter_if.sv
// Control and status bundle for gray_code_counter. The master drives the controls and the slave drives the counts.
// step_err is present only when GRAY_STEP_CHECK_EN is defined.
interface gray_code_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             wrap;
    logic [WIDTH-1:0] dec_out;
    logic             dec_ok;
`ifdef GRAY_STEP_CHECK_EN
    logic             step_err;
`endif

    modport master (
        output en, up_dn, load, load_val,
`ifdef GRAY_STEP_CHECK_EN
        input  step_err,
`endif
        input  bin_out, gray_out, wrap, dec_out, dec_ok
    );

    modport slave (
        input  en, up_dn, load, load_val,
`ifdef GRAY_STEP_CHECK_EN
        output step_err,
`endif
        output bin_out, gray_out, wrap, dec_out, dec_ok
    );
endinterface

// File: rtl/gray_code_counter.sv
// WIDTH-bit up/down binary counter with a registered Gray copy and a registered Gray-to-binary readback.
// Define GRAY_STEP_CHECK_EN to add a sticky step_err flag that catches Gray steps changing other than one bit.
module gray_code_counter #(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic               clk,
    input  logic               rst,
    gray_code_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] RST_BIN  = RST_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q, gray_q, dec_q;
    logic [WIDTH-1:0] bin_nxt, gray_nxt, dec_c;
    logic             wrap_q, wrap_nxt, cnt_nxt, dec_ok_q;

    // Next binary value: load wins over count, hold otherwise
    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
        cnt_nxt  = 1'b0;
        if (bus.load) begin
            bin_nxt = bus.load_val;
        end else if (bus.en) begin
            cnt_nxt = 1'b1;
            if (bus.up_dn) begin
                bin_nxt  = bin_q + ONE;
                wrap_nxt = &bin_q;
            end else begin
                bin_nxt  = bin_q - ONE;
                wrap_nxt = ~|bin_q;
            end
        end
    end

    // Gray is derived from the next binary value so both registers move on the same edge
    assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it; written flat to avoid a comb chain
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign dec_c[i] = ^gray_q[WIDTH-1:i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= RST_BIN;
            gray_q   <= RST_GRAY;
            wrap_q   <= 1'b0;
            dec_q    <= RST_BIN;
            dec_ok_q <= 1'b1;
        end else begin
            bin_q    <= bin_nxt;
            gray_q   <= gray_nxt;
            wrap_q   <= wrap_nxt;
            dec_q    <= dec_c;
            dec_ok_q <= (dec_c == bin_q);
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] gray_prev_q;
    logic             cnt_q, step_err_q;

    // cnt_q marks that the last edge was a count, so gray_prev_q -> gray_q must be a one-bit step
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_prev_q <= RST_GRAY;
            cnt_q       <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            gray_prev_q <= gray_q;
            cnt_q       <= cnt_nxt;
            if (cnt_q && ($countones(gray_prev_q ^ gray_q) != 1))
                step_err_q <= 1'b1;
        end
    end

    assign bus.step_err = step_err_q;
`else
    logic unused_cnt;
    assign unused_cnt = cnt_nxt;
`endif

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.wrap     = wrap_q;
    assign bus.dec_out  = dec_q;
    assign bus.dec_ok   = dec_ok_q;
endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter. It covers a directed vector table on WIDTH=4, a hand sequence on WIDTH=8/RST_VAL=FE,
// and randomized traffic on both widths. The randomized traffic is checked against a modular-arithmetic reference.
module tb_gray_code_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst8;
    gray_code_counter_if #(.WIDTH(4)) b4();
    gray_code_counter_if #(.WIDTH(8)) b8();

    gray_code_counter #(.WIDTH(4), .RST_VAL(0))     dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));
    gray_code_counter #(.WIDTH(8), .RST_VAL('hFE))  dut8 (.clk(clk), .rst(rst8), .bus(b8.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit rst, en, up, ld;
        int lv;
        int bin, gray;
        bit wrap;
    } vec_t;
    vec_t tv[$];

    function automatic void add(bit r, bit e, bit u, bit l, int lv, int b, int g, bit w);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.ld = l; v.lv = lv;
        v.bin = b; v.gray = g; v.wrap = w;
        tv.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference step: counting is plain modular arithmetic, and dec_out trails the binary count by one edge
    task automatic mstep(input int w, input int rv, input bit r, input bit ld, input bit en,
                         input bit up, input int lv, inout int bin, output int wrp, output int dec);
        int modv, nb;
        modv = 1 << w;
        wrp = 0;
        if (r) begin
            bin = rv;
            dec = rv;
        end else begin
            dec = bin;
            if (ld) bin = lv % modv;
            else if (en) begin
                nb = up ? bin + 1 : bin - 1;
                wrp = (nb >= modv || nb < 0) ? 1 : 0;
                bin = (nb + modv) % modv;
            end
        end
    endtask

    int g_up [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 9, 8, 0};
    int dn_b [7]  = '{4, 3, 2, 1, 0, 'hF, 'hE};
    int dn_g [7]  = '{6, 2, 3, 1, 0, 8, 9};
    int w8_b [4]  = '{'hFF, 'h00, 'h01, 'h02};
    int w8_g [4]  = '{'h80, 'h00, 'h01, 'h03};

    initial begin
        int prev, mb4, mb8, wr, dc, g4p, g8p;
        bit r, ld, en, up;
        logic [31:0] lv;

        rst4 = 1'b1; rst8 = 1'b1;
        b4.en = 0; b4.up_dn = 0; b4.load = 0; b4.load_val = '0;
        b8.en = 0; b8.up_dn = 0; b8.load = 0; b8.load_val = '0;

        // Directed table on the 4-bit instance
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) add(0, 1, 1, 0, 0, i % 16, g_up[i], i == 16);
        add(0, 0, 0, 1, 5, 5, 7, 0);
        for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 0, dn_b[i], dn_g[i], dn_b[i] == 'hF);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 'hE, 9, 0);
        add(0, 1, 1, 1, 'hA, 'hA, 'hF, 0);
        add(0, 0, 1, 1, 8, 8, 'hC, 0);
        add(0, 1, 1, 0, 0, 9, 'hD, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 'hF, 8, 1);

        prev = 0;
        foreach (tv[i]) begin
            rst4 = tv[i].rst; b4.en = tv[i].en; b4.up_dn = tv[i].up;
            b4.load = tv[i].ld; b4.load_val = 4'(tv[i].lv);
            tick();
            rst8 = 1'b0;
            chk("tbl_bin",  32'(b4.bin_out),  tv[i].bin);
            chk("tbl_gray", 32'(b4.gray_out), tv[i].gray);
            chk("tbl_wrap", 32'(b4.wrap),     32'(tv[i].wrap));
            chk("tbl_dec",  32'(b4.dec_out),  tv[i].rst ? 0 : prev);
            chk("tbl_ok",   32'(b4.dec_ok),   1);
`ifdef GRAY_STEP_CHECK_EN
            chk("tbl_serr", 32'(b4.step_err), 0);
`endif
            prev = tv[i].bin;
        end

        // 8-bit instance: reset to FE, then count up across the wrap
        rst8 = 1'b1; b8.en = 1'b1; b8.up_dn = 1'b1;
        tick();
        chk("w8_rst_bin",  32'(b8.bin_out),  'hFE);
        chk("w8_rst_gray", 32'(b8.gray_out), 'h81);
        chk("w8_rst_wrap", 32'(b8.wrap),     0);
        chk("w8_rst_dec",  32'(b8.dec_out),  'hFE);
        chk("w8_rst_ok",   32'(b8.dec_ok),   1);
        rst8 = 1'b0;
        prev = 'hFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w8_bin",  32'(b8.bin_out),  w8_b[i]);
            chk("w8_gray", 32'(b8.gray_out), w8_g[i]);
            chk("w8_wrap", 32'(b8.wrap),     (i == 1) ? 1 : 0);
            chk("w8_dec",  32'(b8.dec_out),  prev);
`ifdef GRAY_STEP_CHECK_EN
            chk("w8_serr", 32'(b8.step_err), 0);
`endif
            prev = w8_b[i];
        end

        // Randomized traffic on both widths against the reference
        mb4 = 0; mb8 = 0; g4p = 0; g8p = 0;
        for (int c = 0; c < 1500; c++) begin
            r  = (c == 0) || ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            lv = $urandom;
            rst4 = r; b4.load = ld; b4.en = en; b4.up_dn = up; b4.load_val = lv[3:0];
            rst8 = r; b8.load = ld; b8.en = en; b8.up_dn = ~up; b8.load_val = lv[11:4];
            tick();

            mstep(4, 0, r, ld, en, up, int'(lv[3:0]), mb4, wr, dc);
            chk("r4_bin",  32'(b4.bin_out),  mb4);
            chk("r4_gray", 32'(b4.gray_out), mb4 ^ (mb4 >> 1));
            chk("r4_wrap", 32'(b4.wrap),     wr);
            chk("r4_dec",  32'(b4.dec_out),  dc);
            chk("r4_ok",   32'(b4.dec_ok),   1);
            if (!r && !ld && en) chk("r4_step", $countones(32'(b4.gray_out) ^ g4p), 1);
            g4p = int'(b4.gray_out);

            mstep(8, 'hFE, r, ld, en, ~up, int'(lv[11:4]), mb8, wr, dc);
            chk("r8_bin",  32'(b8.bin_out),  mb8);
            chk("r8_gray", 32'(b8.gray_out), mb8 ^ (mb8 >> 1));
            chk("r8_wrap", 32'(b8.wrap),     wr);
            chk("r8_dec",  32'(b8.dec_out),  dc);
            chk("r8_ok",   32'(b8.dec_ok),   1);
            if (!r && !ld && en) chk("r8_step", $countones(32'(b8.gray_out) ^ g8p), 1);
            g8p = int'(b8.gray_out);
`ifdef GRAY_STEP_CHECK_EN
            chk("r4_serr", 32'(b4.step_err), 0);
            chk("r8_serr", 32'(b8.step_err), 0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
- Parametrised synchronous up/down counter that keeps a binary count register and produces a registered Gray-coded copy of it.
- Generalises the fixed 4-bit binary-to-Gray conversion to WIDTH bits.
- Adds count enable, direction control, parallel load, a wrap flag and a registered Gray-to-binary readback path.
- Used wherever a single-bit-change sequence is needed, such as pointer generation and position encoding.

Parameters:
- WIDTH, 4, counter and code width in bits; legal range is 2 to 16.
- RST_VAL, 0, binary count value loaded on reset; must be less than 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  count enable
- up_dn  input  1  direction; 1 = increment, 0 = decrement
- load  input  1  parallel load strobe; takes priority over en
- load_val  input  WIDTH  binary value to load
- bin_out  output  WIDTH  registered binary count
- gray_out  output  WIDTH  registered Gray code of bin_out; equals bin_out ^ (bin_out >> 1)
- wrap  output  1  one-cycle pulse when the count wraps
- dec_out  output  WIDTH  registered Gray-to-binary decode of gray_out
- dec_ok  output  1  registered flag, 1 when dec_out equals bin_out delayed by one cycle

Behaviour:
- Clock and reset: single clock domain, clk; rst is synchronous and active-high. The polarity and synchronicity of reset are fixed.
- Reset values:
  - bin_out = RST_VAL
  - gray_out = RST_VAL ^ (RST_VAL >> 1)
  - wrap = 0
  - dec_out = RST_VAL
  - dec_ok = 1
- Priority each rising edge: rst > load > en > hold.
- Load: bin_out <= load_val; gray_out <= load_val ^ (load_val >> 1); wrap <= 0.
- Count, en = 1 and up_dn = 1: bin_out <= bin_out + 1, modulo 2**WIDTH. At all-ones it wraps to 0 and wrap pulses 1 on the same edge.
- Count, en = 1 and up_dn = 0: bin_out <= bin_out - 1, modulo 2**WIDTH. At 0 it wraps to all-ones and wrap pulses 1.
- Hold, en = 0: bin_out and gray_out hold; wrap <= 0.
- Gray update: gray_out is computed from the next binary value, not the current one. This gives latency 1 from the control input to both bin_out and gray_out, which always change on the same edge and stay consistent.
- Single-bit property: every count step changes exactly one bit of gray_out, including both wrap transitions. Load and reset may change any number of bits.
- Decode path:
  - dec_out <= prefix XOR of gray_out, MSB first: dec[W-1] = g[W-1]; dec[i] = dec[i+1] ^ g[i].
  - Latency is 1 cycle after gray_out, so 2 cycles after the control input.
  - dec_ok <= (decoded value == bin_out) evaluated one cycle later. It is 1 in all legal operation.
- Simultaneous events:
  - load together with en: the load wins and no count occurs.
  - rst together with anything: reset wins.
  - A direction change takes effect on the edge where it is sampled; there is no extra delay.
- Reset mid-count: the next edge returns all outputs to their reset values. No partial state survives.
- Width rules: all arithmetic is WIDTH bits. There is no carry-out port; overflow is signalled only by wrap.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- With the macro defined:
  - Adds output step_err, 1 bit, reset value 0.
  - On any edge where a count occurred in the previous cycle (not load, not reset), step_err <= 1 if the popcount of (gray_out_prev ^ gray_out) is not 1.
  - step_err is sticky until rst.
- Without the macro: the step_err port and its logic are absent. Interface and behaviour are otherwise identical.

Test Plan:
- Reset with WIDTH=4, RST_VAL=0, then en=1, up_dn=1 for 16 cycles -> gray_out runs 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 (hex); wrap=1 only on the F->0 binary edge; dec_ok stays 1.
- Load load_val=5, then count down 7 cycles -> bin_out 5,4,3,2,1,0,F,E; gray_out 7,6,2,3,1,0,8,9; wrap=1 on the 0->F edge.
- load=1 and en=1 with load_val=A asserted on the same edge -> bin_out=A, gray_out=F next cycle; no increment; wrap=0.
- Assert rst mid-count at bin_out=9 with en=1 -> next edge bin_out=0, gray_out=0, wrap=0, dec_out=0.
- WIDTH=8, RST_VAL=8'hFE, up count 4 cycles -> bin_out FE,FF,00,01,02; gray_out 81,80,00,01,03; one wrap pulse; with GRAY_STEP_CHECK_EN defined, step_err stays 0.
- Toggle en=0 for 3 cycles mid-sequence -> all outputs hold, wrap=0; dec_out tracks gray_out with 1-cycle lag throughout.
